// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage RV32 pipeline. Four hazard
// sources are merged into one set of per-register write enables and
// bubble-inject flushes:
//   - load-use hazard (from hazard detection)
//   - taken branch resolved in EX
//   - multi-cycle mul/div occupying EX
//   - data-memory wait in MEM
// The enables and flushes are Mealy outputs: they are decoded from the
// registered state and the current inputs, so a stall takes effect in the
// cycle it is requested.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst_n            synchronous active-low reset
//   load_use_hazard  load-use stall request
//   branch_taken_ex  branch/jump in EX resolved taken
//   muldiv_start_ex  mul/div op entering EX this cycle
//   muldiv_done      mul/div result valid (single-cycle pulse)
//   dmem_req         MEM stage issuing a load/store
//   dmem_ready       data memory completes the access this cycle
//   pc_write         PC enable
//   if_id_write      IF/ID enable
//   if_id_flush      IF/ID loads a NOP
//   id_ex_write      ID/EX enable
//   id_ex_flush      ID/EX loads a bubble
//   ex_mem_write     EX/MEM enable
//   ex_mem_flush     EX/MEM loads a bubble
//   mem_wb_flush     MEM/WB loads a bubble
//   muldiv_timeout   sticky watchdog error, cleared only by reset
//   stall_cycles     saturating count of cycles with pc_write=0
//   ctrl_state       FSM state (0=RUN, 1=MEM_WAIT, 2=MULDIV_WAIT)
//
// State        | meaning
// -------------+--------------------------------------------------------
// RUN          | no long stall pending; single-cycle hazards only
// MEM_WAIT     | data memory access outstanding, whole pipe frozen
// MULDIV_WAIT  | mul/div busy in EX; front end held, EX/MEM fed bubbles

module pipeline_stall_controller #(
    parameter int MAX_MULDIV_CYCLES = 64,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_hazard,
    input  logic             branch_taken_ex,
    input  logic             muldiv_start_ex,
    input  logic             muldiv_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             muldiv_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       ctrl_state
);

    localparam int WC_W = $clog2(MAX_MULDIV_CYCLES + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_MULDIV_CYCLES);
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_MEM_WAIT    = 2'd1,
        ST_MULDIV_WAIT = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              done_q;
    logic              done_d;
    logic [WC_W-1:0]   wait_cnt_q;
    logic [WC_W-1:0]   wait_cnt_d;
    logic              timeout_q;
    logic              timeout_set;
    logic [CNT_W-1:0]  stall_q;

    logic memstall;
    logic wd_hit;

    assign memstall = dmem_req && !dmem_ready;
    assign wd_hit   = (wait_cnt_q >= WC_MAX);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        state_d      = state_q;
        done_d       = done_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_set  = 1'b0;

        if (!rst_n) begin
            // Reset cycle: freeze every register and inject bubbles everywhere.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b0;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = ST_RUN;
            done_d       = 1'b0;
            wait_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_MULDIV_WAIT: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_flush = 1'b1;
                    wait_cnt_d   = wd_hit ? wait_cnt_q : wait_cnt_q + WC_ONE;
                    if (muldiv_done) begin
                        done_d = 1'b1;
                    end
                    // Watchdog only flags when no result has ever shown up.
                    if (wd_hit && !muldiv_done && !done_q) begin
                        timeout_set = 1'b1;
                    end
                    if (memstall) begin
                        // A done arriving here is parked in done_q until MEM frees up.
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                    end else if (muldiv_done || done_q || wd_hit) begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_flush = 1'b0;
                        // The branch in EX is the mul/div op itself's neighbour
                        // only after release, so only load-use matters here.
                        if (load_use_hazard) begin
                            pc_write    = 1'b0;
                            if_id_write = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                        done_d     = 1'b0;
                        wait_cnt_d = '0;
                        state_d    = ST_RUN;
                    end
                end

                // RUN and MEM_WAIT share one decode: a memory stall freezes the
                // pipe and parks in MEM_WAIT, otherwise the single-cycle rules
                // apply (in MEM_WAIT this is the release cycle).
                default: begin
                    if (memstall) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        state_d      = ST_MEM_WAIT;
                    end else if (muldiv_start_ex) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        done_d       = 1'b0;
                        wait_cnt_d   = WC_ONE;
                        state_d      = ST_MULDIV_WAIT;
                    end else if (branch_taken_ex) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = ST_RUN;
                    end else if (load_use_hazard) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            done_q     <= 1'b0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            wait_cnt_q <= wait_cnt_d;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_ONE;
        end
    end

    assign muldiv_timeout = timeout_q;
    assign stall_cycles   = stall_q;
    assign ctrl_state     = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

    localparam int MAXC = 8;
    localparam int CW   = 5;

    // Input vector bits: {rst_n, load_use, branch, start, done, req, ready}
    localparam logic [6:0] I_R  = 7'b1000000;
    localparam logic [6:0] I_LU = 7'b0100000;
    localparam logic [6:0] I_BR = 7'b0010000;
    localparam logic [6:0] I_ST = 7'b0001000;
    localparam logic [6:0] I_DN = 7'b0000100;
    localparam logic [6:0] I_RQ = 7'b0000010;
    localparam logic [6:0] I_RD = 7'b0000001;

    // Output vector bits: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_f}
    localparam logic [7:0] C_NORM   = 8'b11010100;
    localparam logic [7:0] C_RST    = 8'b00101011;
    localparam logic [7:0] C_FRZ    = 8'b00000001;
    localparam logic [7:0] C_MD     = 8'b00000110;
    localparam logic [7:0] C_MD_MEM = 8'b00000011;
    localparam logic [7:0] C_BR     = 8'b11111100;
    localparam logic [7:0] C_LU     = 8'b00011100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, load_use_hazard, branch_taken_ex, muldiv_start_ex, muldiv_done, dmem_req, dmem_ready;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, ex_mem_flush, mem_wb_flush, muldiv_timeout;
    logic [CW-1:0] stall_cycles;
    logic [1:0]    ctrl_state;
    logic [7:0]    act_ctl;

    assign act_ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                      ex_mem_write, ex_mem_flush, mem_wb_flush};

    pipeline_stall_controller #(.MAX_MULDIV_CYCLES(MAXC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_hazard(load_use_hazard), .branch_taken_ex(branch_taken_ex),
        .muldiv_start_ex(muldiv_start_ex), .muldiv_done(muldiv_done),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .muldiv_timeout(muldiv_timeout), .stall_cycles(stall_cycles), .ctrl_state(ctrl_state)
    );

    typedef struct {
        logic [6:0] in;
        logic [7:0] ctl;
        logic [1:0] st;
        logic       to;
    } vec_t;

    typedef struct {
        string      name;
        int         idx;
        logic [7:0] ctl;
        logic [1:0] st;
        logic [CW-1:0] sc;
        logic       to;
    } exp_t;

    vec_t stim[$];
    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic [CW-1:0] exp_sc = '0;

    task automatic add(input logic [6:0] in, input logic [7:0] ctl, input logic [1:0] st, input logic to);
        vec_t v;
        v.in = in; v.ctl = ctl; v.st = st; v.to = to;
        stim.push_back(v);
    endtask

    // Drive one cycle of stimulus and push what the DUT must show for it.
    // The stall counter expectation follows from the expected pc_write.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        {rst_n, load_use_hazard, branch_taken_ex, muldiv_start_ex,
         muldiv_done, dmem_req, dmem_ready} = v.in;
        e.name = name; e.idx = cyc; e.ctl = v.ctl; e.st = v.st; e.to = v.to; e.sc = exp_sc;
        sb.push_back(e);
        cyc++;
        if (!v.in[6]) exp_sc = '0;
        else if (!v.ctl[7] && exp_sc != {CW{1'b1}}) exp_sc = exp_sc + 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        add(7'b0, C_RST, 2'd0, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        while (stim.size() != 0) begin
            apply(stim.pop_front(), "reset");
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if ({act_ctl, ctrl_state, stall_cycles, muldiv_timeout} !== {e.ctl, e.st, e.sc, e.to}) begin
                n_fail++;
                $display("FAIL %s@%0d: got ctl=%b st=%0d sc=%0d to=%b, want ctl=%b st=%0d sc=%0d to=%b",
                         e.name, e.idx, act_ctl, ctrl_state, stall_cycles, muldiv_timeout, e.ctl, e.st, e.sc, e.to);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        add(I_R | I_LU, C_LU, 2'd0, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        add(I_R | I_LU, C_LU, 2'd0, 1'b0);
        add(I_R | I_LU, C_LU, 2'd0, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        while (stim.size() != 0) begin
            apply(stim.pop_front(), "load_use");
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if ({act_ctl, ctrl_state, stall_cycles, muldiv_timeout} !== {e.ctl, e.st, e.sc, e.to}) begin
                n_fail++;
                $display("FAIL %s@%0d: got ctl=%b st=%0d sc=%0d to=%b, want ctl=%b st=%0d sc=%0d to=%b",
                         e.name, e.idx, act_ctl, ctrl_state, stall_cycles, muldiv_timeout, e.ctl, e.st, e.sc, e.to);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        exp_t e;
        add(7'b0, C_RST, 2'd0, 1'b0);
        add(I_R | I_BR | I_LU, C_BR, 2'd0, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        add(I_R | I_BR, C_BR, 2'd0, 1'b0);
        add(I_R | I_RQ | I_RD, C_NORM, 2'd0, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        while (stim.size() != 0) begin
            apply(stim.pop_front(), "branch");
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if ({act_ctl, ctrl_state, stall_cycles, muldiv_timeout} !== {e.ctl, e.st, e.sc, e.to}) begin
                n_fail++;
                $display("FAIL %s@%0d: got ctl=%b st=%0d sc=%0d to=%b, want ctl=%b st=%0d sc=%0d to=%b",
                         e.name, e.idx, act_ctl, ctrl_state, stall_cycles, muldiv_timeout, e.ctl, e.st, e.sc, e.to);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        exp_t e;
        add(7'b0, C_RST, 2'd0, 1'b0);
        add(I_R | I_RQ, C_FRZ, 2'd0, 1'b0);
        add(I_R | I_RQ, C_FRZ, 2'd1, 1'b0);
        add(I_R | I_RQ, C_FRZ, 2'd1, 1'b0);
        add(I_R | I_RQ | I_RD, C_NORM, 2'd1, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        // memstall outranks start and load-use; release cycle honours start
        add(I_R | I_RQ | I_ST | I_LU, C_FRZ, 2'd0, 1'b0);
        add(I_R | I_RQ | I_RD | I_ST, C_MD, 2'd1, 1'b0);
        add(I_R | I_DN, C_NORM, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        // release cycle honours branch over load-use
        add(I_R | I_RQ, C_FRZ, 2'd0, 1'b0);
        add(I_R | I_RQ | I_RD | I_BR | I_LU, C_BR, 2'd1, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        // dmem_req dropping acts as release
        add(I_R | I_RQ, C_FRZ, 2'd0, 1'b0);
        add(I_R | I_LU, C_LU, 2'd1, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        while (stim.size() != 0) begin
            apply(stim.pop_front(), "mem_wait");
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if ({act_ctl, ctrl_state, stall_cycles, muldiv_timeout} !== {e.ctl, e.st, e.sc, e.to}) begin
                n_fail++;
                $display("FAIL %s@%0d: got ctl=%b st=%0d sc=%0d to=%b, want ctl=%b st=%0d sc=%0d to=%b",
                         e.name, e.idx, act_ctl, ctrl_state, stall_cycles, muldiv_timeout, e.ctl, e.st, e.sc, e.to);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_muldiv_overlap();
        exp_t e;
        add(7'b0, C_RST, 2'd0, 1'b0);
        add(I_R | I_ST, C_MD, 2'd0, 1'b0);
        add(I_R, C_MD, 2'd2, 1'b0);
        add(I_R, C_MD, 2'd2, 1'b0);
        add(I_R | I_RQ, C_MD_MEM, 2'd2, 1'b0);
        add(I_R | I_RQ | I_DN, C_MD_MEM, 2'd2, 1'b0);
        add(I_R | I_RQ, C_MD_MEM, 2'd2, 1'b0);
        add(I_R | I_RQ, C_MD_MEM, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        while (stim.size() != 0) begin
            apply(stim.pop_front(), "muldiv_overlap");
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if ({act_ctl, ctrl_state, stall_cycles, muldiv_timeout} !== {e.ctl, e.st, e.sc, e.to}) begin
                n_fail++;
                $display("FAIL %s@%0d: got ctl=%b st=%0d sc=%0d to=%b, want ctl=%b st=%0d sc=%0d to=%b",
                         e.name, e.idx, act_ctl, ctrl_state, stall_cycles, muldiv_timeout, e.ctl, e.st, e.sc, e.to);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_muldiv_release();
        exp_t e;
        add(7'b0, C_RST, 2'd0, 1'b0);
        add(I_R | I_ST | I_DN, C_MD, 2'd0, 1'b0);
        add(I_R, C_MD, 2'd2, 1'b0);
        add(I_R | I_DN | I_LU | I_BR, C_LU, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        add(I_R | I_ST, C_MD, 2'd0, 1'b0);
        add(I_R | I_DN | I_BR, C_NORM, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        while (stim.size() != 0) begin
            apply(stim.pop_front(), "muldiv_release");
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if ({act_ctl, ctrl_state, stall_cycles, muldiv_timeout} !== {e.ctl, e.st, e.sc, e.to}) begin
                n_fail++;
                $display("FAIL %s@%0d: got ctl=%b st=%0d sc=%0d to=%b, want ctl=%b st=%0d sc=%0d to=%b",
                         e.name, e.idx, act_ctl, ctrl_state, stall_cycles, muldiv_timeout, e.ctl, e.st, e.sc, e.to);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_watchdog();
        exp_t e;
        add(7'b0, C_RST, 2'd0, 1'b0);
        add(I_R | I_ST, C_MD, 2'd0, 1'b0);
        for (int i = 1; i < MAXC; i++) add(I_R, C_MD, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b1);
        add(I_R | I_LU, C_LU, 2'd0, 1'b1);
        add(I_R | I_ST, C_MD, 2'd0, 1'b1);
        add(7'b0, C_RST, 2'd2, 1'b1);
        add(I_R, C_NORM, 2'd0, 1'b0);
        // done arriving exactly at the limit is a normal release
        add(I_R | I_ST, C_MD, 2'd0, 1'b0);
        for (int i = 1; i < MAXC; i++) add(I_R, C_MD, 2'd2, 1'b0);
        add(I_R | I_DN, C_NORM, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        while (stim.size() != 0) begin
            apply(stim.pop_front(), "watchdog");
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if ({act_ctl, ctrl_state, stall_cycles, muldiv_timeout} !== {e.ctl, e.st, e.sc, e.to}) begin
                n_fail++;
                $display("FAIL %s@%0d: got ctl=%b st=%0d sc=%0d to=%b, want ctl=%b st=%0d sc=%0d to=%b",
                         e.name, e.idx, act_ctl, ctrl_state, stall_cycles, muldiv_timeout, e.ctl, e.st, e.sc, e.to);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_muldiv();
        exp_t e;
        add(I_R | I_ST, C_MD, 2'd0, 1'b0);
        add(I_R, C_MD, 2'd2, 1'b0);
        add(I_R | I_RQ | I_DN, C_MD_MEM, 2'd2, 1'b0);
        add(7'b0, C_RST, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        add(I_R | I_DN, C_NORM, 2'd0, 1'b0);
        // parked done must have been discarded by the reset
        add(I_R | I_ST, C_MD, 2'd0, 1'b0);
        add(I_R, C_MD, 2'd2, 1'b0);
        add(I_R, C_MD, 2'd2, 1'b0);
        add(I_R | I_DN, C_NORM, 2'd2, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        while (stim.size() != 0) begin
            apply(stim.pop_front(), "reset_mid_muldiv");
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if ({act_ctl, ctrl_state, stall_cycles, muldiv_timeout} !== {e.ctl, e.st, e.sc, e.to}) begin
                n_fail++;
                $display("FAIL %s@%0d: got ctl=%b st=%0d sc=%0d to=%b, want ctl=%b st=%0d sc=%0d to=%b",
                         e.name, e.idx, act_ctl, ctrl_state, stall_cycles, muldiv_timeout, e.ctl, e.st, e.sc, e.to);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        add(7'b0, C_RST, 2'd0, 1'b0);
        for (int i = 0; i < 34; i++) add(I_R | I_LU, C_LU, 2'd0, 1'b0);
        add(I_R, C_NORM, 2'd0, 1'b0);
        while (stim.size() != 0) begin
            apply(stim.pop_front(), "saturation");
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if ({act_ctl, ctrl_state, stall_cycles, muldiv_timeout} !== {e.ctl, e.st, e.sc, e.to}) begin
                n_fail++;
                $display("FAIL %s@%0d: got ctl=%b st=%0d sc=%0d to=%b, want ctl=%b st=%0d sc=%0d to=%b",
                         e.name, e.idx, act_ctl, ctrl_state, stall_cycles, muldiv_timeout, e.ctl, e.st, e.sc, e.to);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        {rst_n, load_use_hazard, branch_taken_ex, muldiv_start_ex,
         muldiv_done, dmem_req, dmem_ready} = 7'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_muldiv_overlap();
        test_muldiv_release();
        test_watchdog();
        test_reset_mid_muldiv();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Merges four stall/flush sources into one consistent set of per-register write enables and flushes:
  - load-use hazard from hazard detection,
  - taken branch resolved in EX,
  - multi-cycle mul/div in EX,
  - data-memory wait in MEM.
- Holds a 3-state FSM for long stalls, a mul/div watchdog and a saturating stall-cycle performance counter.

Parameters:
MAX_MULDIV_CYCLES, 64, wait cycles in MULDIV_WAIT before watchdog forces release (>=2)
CNT_W, 32, stall performance counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
load_use_hazard  input  1  load-use stall request from hazard detection
branch_taken_ex  input  1  branch/jump in EX resolved taken
muldiv_start_ex  input  1  ID/EX holds a mul/div op entering EX this cycle
muldiv_done  input  1  mul/div result valid (1-cycle pulse)
dmem_req  input  1  MEM stage issuing a load/store
dmem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC register enable
if_id_write  output  1  IF/ID enable
if_id_flush  output  1  IF/ID load NOP
id_ex_write  output  1  ID/EX enable
id_ex_flush  output  1  ID/EX load bubble (all control zero)
ex_mem_write  output  1  EX/MEM enable
ex_mem_flush  output  1  EX/MEM load bubble
mem_wb_flush  output  1  MEM/WB load bubble
muldiv_timeout  output  1  sticky watchdog error
stall_cycles  output  CNT_W  saturating count of cycles with pc_write=0
ctrl_state  output  2  FSM state: 0=RUN, 1=MEM_WAIT, 2=MULDIV_WAIT

Behaviour:
- Outputs are combinational from registered state plus current inputs (Mealy), so a stall takes effect in the request cycle.
- Default (no event): all writes=1, all flushes=0.
- memstall = dmem_req && !dmem_ready.
- Reset:
  - Cycles with rst_n=0: all writes=0, all flushes=1.
  - Registers reset to: state=RUN, stall_cycles=0, muldiv_timeout=0, done_q=0, wait_cnt=0.
- RUN priority (highest first):
  1. memstall: all writes=0, mem_wb_flush=1. Next state MEM_WAIT.
  2. muldiv_start_ex: pc/if_id/id_ex writes=0, ex_mem_flush=1. Next state MULDIV_WAIT, wait_cnt=1. muldiv_done is ignored in the start cycle.
  3. branch_taken_ex: if_id_flush=1, id_ex_flush=1, writes=1. Overrides a simultaneous load_use_hazard.
  4. load_use_hazard: pc_write=0, if_id_write=0, id_ex_flush=1.
- MEM_WAIT:
  - While memstall: full freeze as in RUN rule 1.
  - Cycle dmem_ready=1 (release): MEM completes. Evaluate RUN rules 2-4 this cycle and transition accordingly; otherwise go to RUN.
  - dmem_req dropping while in MEM_WAIT is treated as release.
- MULDIV_WAIT:
  - pc/if_id/id_ex writes=0, ex_mem_flush=1. wait_cnt increments each cycle.
  - done_q sets on muldiv_done; it holds a done that arrives during a MEM stall.
  - memstall present: additionally ex_mem_write=0, mem_wb_flush=1. Stay in MULDIV_WAIT.
  - Release when (muldiv_done || done_q) && !memstall:
    - all writes=1, no flushes,
    - load_use_hazard honoured as in RUN rule 4,
    - branch_taken_ex ignored,
    - clear done_q and wait_cnt, go to RUN.
  - Watchdog: wait_cnt reaching MAX_MULDIV_CYCLES without done sets muldiv_timeout and releases as above. muldiv_timeout clears only on reset.
- stall_cycles: +1 on each non-reset cycle where pc_write=0; saturates at all-ones.
- Reset asserted mid-stall: next cycle state=RUN, all pending done/count state discarded.

Test Plan:
- Load-use: load_use_hazard=1 for 1 cycle in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cycles goes 0->1.
- Branch vs load-use: both asserted together -> if_id_flush=1, id_ex_flush=1, pc_write=1, stall_cycles unchanged.
- Mem wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> all writes=0 and mem_wb_flush=1 for 3 cycles, ctrl_state=1; release cycle writes=1; stall_cycles=3.
- Mul/div with overlapping mem stall: start, done pulses at cycle 4 while memstall active cycles 3-6 -> held in MULDIV_WAIT (done_q=1); release at cycle 7; ex_mem_flush=1 during cycles 0-6.
- Watchdog: MAX_MULDIV_CYCLES=8, start with no done -> muldiv_timeout=1 after 8 wait cycles, ctrl_state=0 next cycle, flag sticky until rst_n=0.
- Reset mid-MULDIV_WAIT: rst_n=0 for 1 cycle -> all writes=0 and flushes=1 that cycle; then ctrl_state=0, stall_cycles=0; a later done pulse has no effect.
